// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//   Instruction-memory responder for a fetch stage. A word array is read when
//   a request is accepted. The word, its address and a fault flag travel
//   through a LATENCY-deep pipeline into an in-order response buffer. Admission
//   is limited by an outstanding-request count, so the buffer cannot overflow.
//   A program-load write port fills the array.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-low reset
//   req_valid  / req_ready / req_addr[63:0]      : fetch request channel
//   rsp_valid  / rsp_ready / rsp_instr[31:0] /
//   rsp_addr[63:0] / rsp_fault                   : response channel
//   flush      : discard every outstanding request
//   prog_we / prog_addr / prog_data[31:0]        : program-load write port
// ---------------------------------------------------------------------------
module imem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2,
   parameter int MAX_OUT     = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [63:0]                    req_addr,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [31:0]                    rsp_instr,
   output logic [63:0]                    rsp_addr,
   output logic                           rsp_fault,
   input  logic                           flush,
   input  logic                           prog_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr,
   input  logic [31:0]                    prog_data
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CW = $clog2(MAX_OUT + 1);

   localparam logic [31:0]   NOP_INSTR = 32'h0000_0013;
   localparam logic [61:0]   DEPTH_W   = 62'(DEPTH_WORDS);
   localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
   localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_OUT - 1);

   // Misaligned or beyond the end of the array.
   function automatic logic addr_fault(input logic [63:0] addr);
      return (addr[1:0] != 2'b00) || (addr[63:2] >= DEPTH_W);
   endfunction

   // Circular buffer pointer advance, safe for non-power-of-two depths.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
      return (ptr == LAST_SLOT) ? {PW{1'b0}} : ptr + {{(PW-1){1'b0}}, 1'b1};
   endfunction

   logic [31:0]        mem_r [DEPTH_WORDS];

   logic [LATENCY-1:0] pipe_v_r;
   logic [LATENCY-1:0] pipe_fault_r;
   logic [31:0]        pipe_instr_r [LATENCY];
   logic [63:0]        pipe_addr_r  [LATENCY];

   logic [31:0]        buf_instr_r [MAX_OUT];
   logic [63:0]        buf_addr_r  [MAX_OUT];
   logic [MAX_OUT-1:0] buf_fault_r;
   logic [PW-1:0]      wr_ptr_r;
   logic [PW-1:0]      rd_ptr_r;
   logic [CW-1:0]      buf_cnt_r;
   logic [CW-1:0]      out_cnt_r;

   logic               accept_s;
   logic               deliver_s;
   logic               push_s;
   logic               req_fault_s;
   logic [AW-1:0]      req_idx_s;
   logic [31:0]        rd_word_s;

   // Handshake qualification, request decode and response head selection
   always_comb begin
      // The count covers pipeline entries and buffered responses alike.
      req_ready   = rst && !flush && (out_cnt_r < MAX_OUT_C);
      rsp_valid   = (buf_cnt_r != {CW{1'b0}});
      accept_s    = req_valid && req_ready;
      deliver_s   = rsp_valid && rsp_ready;
      push_s      = pipe_v_r[LATENCY-1];
      req_idx_s   = req_addr[AW+1:2];
      req_fault_s = addr_fault(req_addr);
      rd_word_s   = req_fault_s ? NOP_INSTR : mem_r[req_idx_s];
      rsp_instr   = buf_instr_r[rd_ptr_r];
      rsp_addr    = buf_addr_r[rd_ptr_r];
      rsp_fault   = buf_fault_r[rd_ptr_r];
   end

   // Program-load write; array contents survive reset, and a read accepted on
   // the same edge sees the old word because both use the pre-edge value.
   always_ff @(posedge clk) begin
      if (prog_we) begin
         mem_r[prog_addr] <= prog_data;
      end
   end

   // Read pipeline: stage 0 captures the array word at the accept edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_v_r     <= {LATENCY{1'b0}};
         pipe_fault_r <= {LATENCY{1'b0}};
         for (int i = 0; i < LATENCY; i++) begin
            pipe_instr_r[i] <= 32'h0000_0000;
            pipe_addr_r[i]  <= 64'h0;
         end
      end else begin
         if (flush) begin
            pipe_v_r <= {LATENCY{1'b0}};
         end else begin
            pipe_v_r[0] <= accept_s;
            for (int i = 1; i < LATENCY; i++) begin
               pipe_v_r[i] <= pipe_v_r[i-1];
            end
         end
         // Payload shifts freely; only the valid bits carry meaning.
         pipe_instr_r[0] <= rd_word_s;
         pipe_addr_r[0]  <= req_addr;
         pipe_fault_r[0] <= req_fault_s;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_instr_r[i] <= pipe_instr_r[i-1];
            pipe_addr_r[i]  <= pipe_addr_r[i-1];
            pipe_fault_r[i] <= pipe_fault_r[i-1];
         end
      end
   end

   // In-order response buffer fed by the last pipeline stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         buf_cnt_r   <= {CW{1'b0}};
         buf_fault_r <= {MAX_OUT{1'b0}};
         for (int i = 0; i < MAX_OUT; i++) begin
            buf_instr_r[i] <= 32'h0000_0000;
            buf_addr_r[i]  <= 64'h0;
         end
      end else if (flush) begin
         // A delivery in this cycle has already been seen by the consumer;
         // everything behind it is dropped.
         wr_ptr_r  <= {PW{1'b0}};
         rd_ptr_r  <= {PW{1'b0}};
         buf_cnt_r <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            buf_instr_r[wr_ptr_r] <= pipe_instr_r[LATENCY-1];
            buf_addr_r[wr_ptr_r]  <= pipe_addr_r[LATENCY-1];
            buf_fault_r[wr_ptr_r] <= pipe_fault_r[LATENCY-1];
            wr_ptr_r              <= next_ptr(wr_ptr_r);
         end
         if (deliver_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
         case ({push_s, deliver_s})
            2'b10:   buf_cnt_r <= buf_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   buf_cnt_r <= buf_cnt_r - {{(CW-1){1'b0}}, 1'b1};
            default: buf_cnt_r <= buf_cnt_r;
         endcase
      end
   end

   // Outstanding-request count used for admission control.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_cnt_r <= {CW{1'b0}};
      end else if (flush) begin
         out_cnt_r <= {CW{1'b0}};
      end else begin
         case ({accept_s, deliver_s})
            2'b10:   out_cnt_r <= out_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   out_cnt_r <= out_cnt_r - {{(CW-1){1'b0}}, 1'b1};
            default: out_cnt_r <= out_cnt_r;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
//   Directed, table-driven bench for imem_responder (LATENCY=2, MAX_OUT=4,
//   DEPTH_WORDS=1024). Each table row gives the inputs for one clock cycle and
//   the outputs expected during that cycle, before its rising edge.
// ---------------------------------------------------------------------------
module tb_imem_responder;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] W0  = 32'h0050_0093;
   localparam logic [31:0] W1  = 32'h00A0_0113;
   localparam logic [31:0] W2  = 32'h0000_0202;
   localparam logic [31:0] W3  = 32'h0000_0303;
   localparam logic [31:0] W4  = 32'h0000_0404;
   localparam logic [31:0] W5O = 32'h1111_1111;
   localparam logic [31:0] W5N = 32'h2222_2222;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic [63:0] rsp_addr;
   logic        rsp_fault;
   logic        flush;
   logic        prog_we;
   logic [9:0]  prog_addr;
   logic [31:0] prog_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       nm;
      logic        fl;
      logic        rqv;
      logic [63:0] addr;
      logic        rsr;
      logic        e_rv;
      logic        e_rdy;
      logic        e_chk;
      logic [31:0] e_instr;
      logic [63:0] e_addr;
      logic        e_fault;
      logic        pw;
      logic [9:0]  pa;
      logic [31:0] pd;
   } vec_t;

   vec_t vecs[$];

   imem_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY    (2),
      .MAX_OUT    (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr (req_addr),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_instr(rsp_instr),
      .rsp_addr (rsp_addr),
      .rsp_fault(rsp_fault),
      .flush    (flush),
      .prog_we  (prog_we),
      .prog_addr(prog_addr),
      .prog_data(prog_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string nm, input logic fl, input logic rqv,
                               input logic [63:0] addr, input logic rsr,
                               input logic e_rv, input logic e_rdy, input logic e_chk,
                               input logic [31:0] e_instr = 32'h0,
                               input logic [63:0] e_addr = 64'h0,
                               input logic e_fault = 1'b0,
                               input logic pw = 1'b0, input logic [9:0] pa = 10'd0,
                               input logic [31:0] pd = 32'h0);
      vec_t v;
      v.nm = nm; v.fl = fl; v.rqv = rqv; v.addr = addr; v.rsr = rsr;
      v.e_rv = e_rv; v.e_rdy = e_rdy; v.e_chk = e_chk;
      v.e_instr = e_instr; v.e_addr = e_addr; v.e_fault = e_fault;
      v.pw = pw; v.pa = pa; v.pd = pd;
      return v;
   endfunction

   task automatic load(input logic [9:0] a, input logic [31:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      @(posedge clk); #1;
      prog_we   = 1'b0;
   endtask

   task automatic set_req(input logic v, input logic [63:0] a, input logic r);
      req_valid = v;
      req_addr  = a;
      rsp_ready = r;
   endtask

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_addr = 64'h0; rsp_ready = 1'b0;
      flush = 1'b0; prog_we = 1'b0; prog_addr = 10'd0; prog_data = 32'h0;

      // Reset state
      #2;
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_req_ready", 64'(req_ready), 64'h0);
      chk("rst_rsp_instr", 64'(rsp_instr), 64'h0);
      chk("rst_rsp_addr",  rsp_addr,       64'h0);
      chk("rst_rsp_fault", 64'(rsp_fault), 64'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", 64'(req_ready), 64'h1);
      @(posedge clk); #1;

      load(10'd0, W0); load(10'd1, W1); load(10'd2, W2);
      load(10'd3, W3); load(10'd4, W4); load(10'd5, W5O);

      // Back-to-back fetch with the consumer always ready
      vecs.push_back(mk("b2b0", 0, 1, 64'h0, 1, 0, 1, 0));
      vecs.push_back(mk("b2b1", 0, 1, 64'h4, 1, 0, 1, 0));
      vecs.push_back(mk("b2b2", 0, 0, 64'h0, 1, 0, 1, 0));
      vecs.push_back(mk("b2b3", 0, 0, 64'h0, 1, 1, 1, 1, W0, 64'h0, 0));
      vecs.push_back(mk("b2b4", 0, 0, 64'h0, 1, 1, 1, 1, W1, 64'h4, 0));
      vecs.push_back(mk("b2b5", 0, 0, 64'h0, 1, 0, 1, 0));
      // Misaligned and out-of-range addresses
      vecs.push_back(mk("flt0", 0, 1, 64'h2, 1, 0, 1, 0));
      vecs.push_back(mk("flt1", 0, 1, 64'h1000, 1, 0, 1, 0));
      vecs.push_back(mk("flt2", 0, 1, 64'h1_0000_0000, 1, 0, 1, 0));
      vecs.push_back(mk("flt3", 0, 0, 64'h0, 1, 1, 1, 1, NOP, 64'h2, 1));
      vecs.push_back(mk("flt4", 0, 0, 64'h0, 1, 1, 1, 1, NOP, 64'h1000, 1));
      vecs.push_back(mk("flt5", 0, 0, 64'h0, 1, 1, 1, 1, NOP, 64'h1_0000_0000, 1));
      vecs.push_back(mk("flt6", 0, 0, 64'h0, 1, 0, 1, 0));
      // Consumer stalled: admission stops at four, head holds steady
      vecs.push_back(mk("stl0", 0, 1, 64'h0,  0, 0, 1, 0));
      vecs.push_back(mk("stl1", 0, 1, 64'h4,  0, 0, 1, 0));
      vecs.push_back(mk("stl2", 0, 1, 64'h8,  0, 0, 1, 0));
      vecs.push_back(mk("stl3", 0, 1, 64'hC,  0, 1, 1, 1, W0, 64'h0, 0));
      vecs.push_back(mk("stl4", 0, 1, 64'h10, 0, 1, 0, 1, W0, 64'h0, 0));
      vecs.push_back(mk("stl5", 0, 1, 64'h14, 0, 1, 0, 1, W0, 64'h0, 0));
      vecs.push_back(mk("stl6", 0, 0, 64'h0,  1, 1, 0, 1, W0, 64'h0, 0));
      vecs.push_back(mk("stl7", 0, 0, 64'h0,  1, 1, 1, 1, W1, 64'h4, 0));
      vecs.push_back(mk("stl8", 0, 0, 64'h0,  1, 1, 1, 1, W2, 64'h8, 0));
      vecs.push_back(mk("stl9", 0, 0, 64'h0,  1, 1, 1, 1, W3, 64'hC, 0));
      vecs.push_back(mk("stlA", 0, 0, 64'h0,  1, 0, 1, 0));
      // Flush with three outstanding and a request presented in the flush cycle
      vecs.push_back(mk("fls0", 0, 1, 64'h0, 0, 0, 1, 0));
      vecs.push_back(mk("fls1", 0, 1, 64'h4, 0, 0, 1, 0));
      vecs.push_back(mk("fls2", 0, 1, 64'h8, 0, 0, 1, 0));
      vecs.push_back(mk("fls3", 1, 1, 64'hC, 0, 1, 0, 1, W0, 64'h0, 0));
      vecs.push_back(mk("fls4", 0, 0, 64'h0, 0, 0, 1, 0));
      vecs.push_back(mk("fls5", 0, 0, 64'h0, 0, 0, 1, 0));
      vecs.push_back(mk("fls6", 0, 1, 64'h4, 0, 0, 1, 0));
      vecs.push_back(mk("fls7", 0, 1, 64'h8, 0, 0, 1, 0));
      vecs.push_back(mk("fls8", 0, 1, 64'hC, 0, 0, 1, 0));
      vecs.push_back(mk("fls9", 0, 1, 64'h0, 0, 1, 1, 1, W1, 64'h4, 0));
      vecs.push_back(mk("flsA", 0, 0, 64'h0, 1, 1, 0, 1, W1, 64'h4, 0));
      vecs.push_back(mk("flsB", 0, 0, 64'h0, 1, 1, 1, 1, W2, 64'h8, 0));
      vecs.push_back(mk("flsC", 0, 0, 64'h0, 1, 1, 1, 1, W3, 64'hC, 0));
      vecs.push_back(mk("flsD", 0, 0, 64'h0, 1, 1, 1, 1, W0, 64'h0, 0));
      vecs.push_back(mk("flsE", 0, 0, 64'h0, 1, 0, 1, 0));
      // Program write to the word being fetched on the same edge
      vecs.push_back(mk("prg0", 0, 1, 64'h14, 1, 0, 1, 0, 32'h0, 64'h0, 0, 1, 10'd5, W5N));
      vecs.push_back(mk("prg1", 0, 1, 64'h14, 1, 0, 1, 0));
      vecs.push_back(mk("prg2", 0, 0, 64'h0,  1, 0, 1, 0));
      vecs.push_back(mk("prg3", 0, 0, 64'h0,  1, 1, 1, 1, W5O, 64'h14, 0));
      vecs.push_back(mk("prg4", 0, 0, 64'h0,  1, 1, 1, 1, W5N, 64'h14, 0));
      vecs.push_back(mk("prg5", 0, 0, 64'h0,  1, 0, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         flush     = vecs[i].fl;
         req_valid = vecs[i].rqv;
         req_addr  = vecs[i].addr;
         rsp_ready = vecs[i].rsr;
         prog_we   = vecs[i].pw;
         prog_addr = vecs[i].pa;
         prog_data = vecs[i].pd;
         @(negedge clk);
         chk({vecs[i].nm, ".rsp_valid"}, 64'(rsp_valid), 64'(vecs[i].e_rv));
         chk({vecs[i].nm, ".req_ready"}, 64'(req_ready), 64'(vecs[i].e_rdy));
         if (vecs[i].e_chk) begin
            chk({vecs[i].nm, ".rsp_instr"}, 64'(rsp_instr), 64'(vecs[i].e_instr));
            chk({vecs[i].nm, ".rsp_addr"},  rsp_addr,       vecs[i].e_addr);
            chk({vecs[i].nm, ".rsp_fault"}, 64'(rsp_fault), 64'(vecs[i].e_fault));
         end
         @(posedge clk); #1;
      end
      flush = 1'b0; prog_we = 1'b0;

      // Reset in the middle of a burst
      set_req(1'b1, 64'h0, 1'b1);
      @(posedge clk); #1 set_req(1'b1, 64'h4, 1'b1);
      @(posedge clk); #1 set_req(1'b1, 64'h8, 1'b1);
      @(posedge clk); #1 set_req(1'b0, 64'h0, 1'b1);
      @(negedge clk);
      chk("mid_pre_rsp_valid", 64'(rsp_valid), 64'h1);
      chk("mid_pre_rsp_instr", 64'(rsp_instr), 64'(W0));
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("mid_rst_req_ready", 64'(req_ready), 64'h0);
      chk("mid_rst_rsp_instr", 64'(rsp_instr), 64'h0);
      chk("mid_rst_rsp_addr",  rsp_addr,       64'h0);
      @(posedge clk); #1 rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("post_mid_rsp_valid", 64'(rsp_valid), 64'h0);
         chk("post_mid_req_ready", 64'(req_ready), 64'h1);
         @(posedge clk); #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: instruction array size in 32-bit words; power of two.
REQ-002 Parameter LATENCY, default 2: cycles from request accept to earliest rsp_valid; legal range 1..4.
REQ-003 Parameter MAX_OUT, default 4: maximum outstanding (accepted, not yet delivered) requests; also the response buffer depth.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  fetch stage presents a fetch address.
REQ-007 req_ready  output  1  responder accepts the request this cycle.
REQ-008 req_addr  input  64  byte address of the instruction.
REQ-009 rsp_valid  output  1  response available at the buffer head.
REQ-010 rsp_ready  input  1  fetch stage consumes the response this cycle.
REQ-011 rsp_instr  output  32  instruction word.
REQ-012 rsp_addr  output  64  request address echoed with the response.
REQ-013 rsp_fault  output  1  request was misaligned or out of range.
REQ-014 flush  input  1  redirect (taken branch or jump): discard all outstanding requests.
REQ-015 prog_we  input  1  program-load write enable.
REQ-016 prog_addr  input  clog2(DEPTH_WORDS)  word index for the program-load write.
REQ-017 prog_data  input  32  program-load write data.

Function
REQ-018 Request accepted iff req_valid && req_ready at the rising edge; response delivered iff rsp_valid && rsp_ready.
REQ-019 req_ready = !flush && (outstanding < MAX_OUT); the count includes in-flight pipeline entries and buffered responses; req_ready does not depend combinationally on req_valid.
REQ-020 Array read at the accept edge using word index req_addr[clog2(DEPTH_WORDS)+1:2]; the result travels a LATENCY-stage pipeline with the address and fault flag, then enters the response FIFO.
REQ-021 Accept at edge N: rsp_valid asserts after edge N+LATENCY at the earliest; responses are delivered strictly in acceptance order.
REQ-022 Throughput is one accept and one delivery per cycle; with rsp_ready held high, back-to-back requests yield back-to-back responses.
REQ-023 Fault when req_addr[1:0] != 0 or req_addr[63:2] >= DEPTH_WORDS: rsp_fault=1, rsp_instr=32'h00000013 (NOP); otherwise rsp_fault=0.
REQ-024 rsp_valid low with rsp_ready high: nothing is consumed; rsp_valid high with rsp_ready low: rsp_instr, rsp_addr and rsp_fault hold stable and rsp_valid stays high.
REQ-025 Outstanding count: +1 on accept, -1 on delivery, unchanged when both occur in the same cycle; the buffer never overflows because admission is limited by REQ-019.
REQ-026 Flush at edge N: all pipeline stages and buffer entries are invalidated and the count is zeroed; rsp_valid is low after edge N; req_ready is low during the flush cycle; a delivery handshake in the flush cycle is still honored; no request is accepted in the flush cycle.
REQ-027 prog_we writes prog_data to prog_addr at the edge; a read accepted at the same edge to the same word returns the old data; reads accepted at later edges return the new data.
REQ-028 Writes proceed regardless of flush or stall; the array holds no read or write ordering state other than REQ-027.

Reset
REQ-029 rst low asynchronously clears all pipeline valids, the buffer pointers and the outstanding count: rsp_valid=0, req_ready=0 while rst is low, rsp_instr=0, rsp_addr=0, rsp_fault=0.
REQ-030 req_ready=1 on the first cycle after rst is released; array contents are not reset.
REQ-031 Reset asserted mid-operation discards all outstanding requests with no partial response.

Verification (LATENCY=2, MAX_OUT=4, DEPTH_WORDS=1024)
REQ-032 Load word 0=32'h00500093, word 1=32'h00A00113; request 0x0 then 0x4 back-to-back with rsp_ready=1 -> responses at cycles N+2 and N+3, correct data, rsp_fault=0.
REQ-033 rsp_ready=0; issue 6 requests -> 4 accepted, req_ready=0 after the 4th; rsp data stable; raise rsp_ready -> 4 in-order responses, req_ready returns to 1.
REQ-034 Request 0x2 and then 0x1000 -> both rsp_fault=1, rsp_instr=32'h00000013, rsp_addr echoed.
REQ-035 3 outstanding requests, then flush pulse with req_valid high -> rsp_valid=0 after the edge, no stale responses, the flush-cycle request is not accepted, and the next request returns normally.
REQ-036 prog_we to word 5 in the same cycle as accepting 0x14 -> old data returned; re-request -> new data. Reset asserted mid-burst -> rsp_valid=0 immediately, no responses after release.
